// File: rtl/ulpi_reg_pkg.sv
// ulpi_reg_pkg
//   Shared types and constants for the ULPI register-port arbiter:
//   PHY register addresses, the init-script step record and script,
//   the arbiter state enum and the attempt-counter width.
package ulpi_reg_pkg;

  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int MAX_RETRY_DEF   = 3;

  // Holds 1 + MAX_RETRY attempts plus the overflow value.
  localparam int ATT_W = 3;

  // One init-script step. check=1 means the read result must equal data.
  typedef struct packed {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data;
    logic       check;
  } init_step_t;

  // Element 0 is the leftmost entry.
  localparam init_step_t [0:3] INIT_SCRIPT = {
    {1'b1, FUNC_CTRL, 8'h60, 1'b0},  // Reset + SuspendM
    {1'b1, OTG_CTRL,  8'h00, 1'b0},  // OTG pulldowns off
    {1'b1, FUNC_CTRL, 8'h45, 1'b0},  // SuspendM, TermSelect, XcvrSelect=FS
    {1'b0, FUNC_CTRL, 8'h45, 1'b1}   // read back FUNC_CTRL
  };

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT,
    S_GUARD,
    S_NEXT,
    S_GRANT
  } arb_state_t;

endpackage

// File: rtl/ulpi_reg_arbiter_if.sv
// ulpi_reg_arbiter_if
//   Bundles the link-controller register port, both requester ports and
//   the init status flags.
//   master : arbiter side (drives REG_*, *_ACK/*_ERR/*_RDATA, INIT_*)
//   slave  : environment side (link controller + requesters)
interface ulpi_reg_arbiter_if;
  // link controller
  logic       ULPI_READY;
  logic       ULPI_REG_DONE;
  logic       ULPI_REG_FAIL;
  logic [7:0] ULPI_REG_DATA_O;
  logic       REG_EN;
  logic       REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I;
  // requester A
  logic       A_REQ;
  logic       A_RW;
  logic [5:0] A_ADDR;
  logic [7:0] A_WDATA;
  logic       A_ACK;
  logic       A_ERR;
  logic [7:0] A_RDATA;
  // requester B
  logic       B_REQ;
  logic       B_RW;
  logic [5:0] B_ADDR;
  logic [7:0] B_WDATA;
  logic       B_ACK;
  logic       B_ERR;
  logic [7:0] B_RDATA;
  // status
  logic       INIT_DONE;
  logic       INIT_ERR;

  modport master (
    input  ULPI_READY, ULPI_REG_DONE, ULPI_REG_FAIL, ULPI_REG_DATA_O,
    output REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
    input  A_REQ, A_RW, A_ADDR, A_WDATA,
    output A_ACK, A_ERR, A_RDATA,
    input  B_REQ, B_RW, B_ADDR, B_WDATA,
    output B_ACK, B_ERR, B_RDATA,
    output INIT_DONE, INIT_ERR
  );

  modport slave (
    output ULPI_READY, ULPI_REG_DONE, ULPI_REG_FAIL, ULPI_REG_DATA_O,
    input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
    output A_REQ, A_RW, A_ADDR, A_WDATA,
    input  A_ACK, A_ERR, A_RDATA,
    output B_REQ, B_RW, B_ADDR, B_WDATA,
    input  B_ACK, B_ERR, B_RDATA,
    input  INIT_DONE, INIT_ERR
  );
endinterface

// File: rtl/ulpi_reg_arbiter_init_rom.sv
// ulpi_init_rom
//   Combinational lookup of the PHY init script.
//   idx_i  : step index 0..3
//   step_o : step record (rw, addr, data, check)
//   last_o : high on the final step
module ulpi_init_rom
  import ulpi_reg_pkg::*;
(
  input  logic [1:0] idx_i,
  output init_step_t step_o,
  output logic       last_o
);
  assign step_o = INIT_SCRIPT[idx_i];
  assign last_o = (idx_i == 2'd3);
endmodule

// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter
//   Owns the ULPI link controller's register port. After reset it runs the
//   PHY init script, then shares the port between requesters A and B with
//   round-robin arbitration, retrying failed/timed-out accesses.
//   CLK_60M    : ULPI clock, rising edge
//   NRST_A_USB : asynchronous active-low reset
//   bus        : register port, requester A/B ports, INIT_DONE/INIT_ERR
module ulpi_reg_arbiter
  import ulpi_reg_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input logic                CLK_60M,
  input logic                NRST_A_USB,
  ulpi_reg_arbiter_if.master bus
);

  localparam logic [7:0]       TMO_MAX = 8'(TIMEOUT_CYC);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);

  arb_state_t       state_q;
  logic [1:0]       step_q;
  logic [ATT_W-1:0] att_q;
  logic [7:0]       tmo_q;
  logic             retry_q;     // GUARD re-issues the same op
  logic             sel_b_q;     // current arbitrated op belongs to B
  logic             rr_q;        // 1: B is favoured on contention
  logic             done_prev_q;
  logic             reg_en_q, reg_rw_q;
  logic [5:0]       reg_addr_q;
  logic [7:0]       reg_data_q;
  logic             a_ack_q, a_err_q, b_ack_q, b_err_q;
  logic [7:0]       a_rdata_q, b_rdata_q;
  logic             init_done_q, init_err_q;

  init_step_t       rom_step;
  logic             rom_last;
  logic             done_rise, tmo_hit, a_win;
  logic [ATT_W-1:0] att_inc;

  ulpi_init_rom u_rom (
    .idx_i  (step_q),
    .step_o (rom_step),
    .last_o (rom_last)
  );

  assign done_rise = bus.ULPI_REG_DONE && !done_prev_q;
  assign tmo_hit   = (tmo_q == TMO_MAX);
  assign att_inc   = att_q + 1'b1;
  assign a_win     = bus.A_REQ && (!bus.B_REQ || !rr_q);

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q     <= S_WAIT_RDY;
      step_q      <= '0;
      att_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= 1'b0;
      sel_b_q     <= 1'b0;
      rr_q        <= 1'b0;
      done_prev_q <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_rw_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      reg_en_q    <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      done_prev_q <= bus.ULPI_REG_DONE;
      case (state_q)
        S_WAIT_RDY: begin
          if (bus.ULPI_READY) begin
            reg_rw_q   <= rom_step.rw;
            reg_addr_q <= rom_step.addr;
            reg_data_q <= rom_step.data;
            att_q      <= '0;
            reg_en_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // FAIL is tested first so it wins over a simultaneous DONE.
          if (bus.ULPI_REG_FAIL || tmo_hit) begin
            att_q   <= att_inc;
            state_q <= S_GUARD;
            if (att_inc <= ATT_MAX) begin
              retry_q <= 1'b1;
            end else begin
              retry_q <= 1'b0;
              if (!init_done_q) begin
                // A dead init step is flagged but the script carries on.
                init_err_q <= 1'b1;
                if (rom_last) init_done_q <= 1'b1;
                else          step_q      <= step_q + 2'd1;
              end else if (sel_b_q) begin
                b_err_q <= 1'b1;
              end else begin
                a_err_q <= 1'b1;
              end
            end
          end else if (done_rise) begin
            retry_q <= 1'b0;
            state_q <= S_GUARD;
            if (!init_done_q) begin
              if (rom_step.check && (bus.ULPI_REG_DATA_O != rom_step.data))
                init_err_q <= 1'b1;
              if (rom_last) init_done_q <= 1'b1;
              else          step_q      <= step_q + 2'd1;
            end else if (sel_b_q) begin
              b_ack_q   <= 1'b1;
              b_rdata_q <= bus.ULPI_REG_DATA_O;
            end else begin
              a_ack_q   <= 1'b1;
              a_rdata_q <= bus.ULPI_REG_DATA_O;
            end
          end else if (bus.ULPI_READY) begin
            // Frozen while the PHY is not ready; saturates via tmo_hit.
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_GUARD: begin
          if (!bus.ULPI_REG_DONE && bus.ULPI_READY) begin
            if (retry_q) begin
              reg_en_q <= 1'b1;
              state_q  <= S_ISSUE;
            end else begin
              state_q  <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (!init_done_q) begin
            reg_rw_q   <= rom_step.rw;
            reg_addr_q <= rom_step.addr;
            reg_data_q <= rom_step.data;
            att_q      <= '0;
            reg_en_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            state_q    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (bus.A_REQ || bus.B_REQ) begin
            sel_b_q    <= !a_win;
            reg_rw_q   <= a_win ? bus.A_RW    : bus.B_RW;
            reg_addr_q <= a_win ? bus.A_ADDR  : bus.B_ADDR;
            reg_data_q <= a_win ? bus.A_WDATA : bus.B_WDATA;
            // The pointer moves only on contention, to the losing port.
            if (bus.A_REQ && bus.B_REQ) rr_q <= a_win;
            att_q      <= '0;
            reg_en_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        default: state_q <= S_WAIT_RDY;
      endcase
    end
  end

  assign bus.REG_EN     = reg_en_q;
  assign bus.REG_RW     = reg_rw_q;
  assign bus.REG_ADDR   = reg_addr_q;
  assign bus.REG_DATA_I = reg_data_q;
  assign bus.A_ACK      = a_ack_q;
  assign bus.A_ERR      = a_err_q;
  assign bus.A_RDATA    = a_rdata_q;
  assign bus.B_ACK      = b_ack_q;
  assign bus.B_ERR      = b_err_q;
  assign bus.B_RDATA    = b_rdata_q;
  assign bus.INIT_DONE  = init_done_q;
  assign bus.INIT_ERR   = init_err_q;

endmodule
